// File: rtl/if_id_stage.sv
// Instruction-fetch stage and IF/ID pipeline register.
// Holds the fetch PC and drives the instruction-memory address.
// Latches the fetched word for register-file decode.
// Detects load-use hazards, which stall fetch.
// Redirects and flushes on taken branches resolved in EX.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000,
  parameter int          CNT_WIDTH = 16
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  output logic [31:0]          IMEM_ADDR,
  input  logic [31:0]          IMEM_DATA,
  input  logic                 ID_EX_MemRead,
  input  logic [4:0]           ID_EX_RT,
  input  logic                 BranchTaken,
  input  logic [31:0]          BranchTarget,
  output logic [31:0]          PC,
  output logic [31:0]          Instruction,
  output logic [31:0]          PCPlus4,
  output logic                 Valid,
  output logic                 Stall,
  output logic [CNT_WIDTH-1:0] StallCount,
  output logic [CNT_WIDTH-1:0] FlushCount
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [31:0] next_seq_pc;
  logic [4:0]  rs_field;
  logic [4:0]  rt_field;
  logic        do_flush;
  logic        do_stall;

  // The memory is combinational, so the address is the PC itself with no register between them.
  assign IMEM_ADDR   = PC;
  assign next_seq_pc = PC + 32'd4;
  assign rs_field    = Instruction[25:21];
  assign rt_field    = Instruction[20:16];

  // Load-use hazard check on the instruction in IF/ID; both fields are compared whatever the opcode.
  always_comb begin
    Stall = Valid & ID_EX_MemRead & (ID_EX_RT != 5'd0) &
            ((ID_EX_RT == rs_field) | (ID_EX_RT == rt_field));
  end

  // A taken branch is older than the stalled instruction, so the flush takes priority.
  always_comb begin
    do_flush = BranchTaken;
    do_stall = ~BranchTaken & Stall;
  end

  // PC and IF/ID register: flush inserts a bubble, stall holds, otherwise advance.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      PC          <= RESET_PC;
      Instruction <= NOP_WORD;
      PCPlus4     <= 32'd0;
      Valid       <= 1'b0;
    end else if (do_flush) begin
      PC          <= {BranchTarget[31:2], 2'b00};
      Instruction <= NOP_WORD;
      PCPlus4     <= 32'd0;
      Valid       <= 1'b0;
    end else if (!do_stall) begin
      PC          <= next_seq_pc;
      Instruction <= IMEM_DATA;
      PCPlus4     <= next_seq_pc;
      Valid       <= 1'b1;
    end
  end

  // Saturating performance counters for stall cycles and flushes; they stick at all-ones.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (do_stall && StallCount != CNT_MAX) begin
        StallCount <= StallCount + CNT_ONE;
      end
      if (do_flush && FlushCount != CNT_MAX) begin
        FlushCount <= FlushCount + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed testbench for if_id_stage with hand-computed expectations.
// The DUT uses 2-bit counters so that saturation is reachable in a few cycles.
module tb_if_id_stage;

  logic        CLOCK;
  logic        RESET;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_DATA;
  logic        ID_EX_MemRead;
  logic [4:0]  ID_EX_RT;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic [31:0] PCPlus4;
  logic        Valid;
  logic        Stall;
  logic [1:0]  StallCount;
  logic [1:0]  FlushCount;

  int vecCount;
  int failCount;

  if_id_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_WORD (32'h0000_0000),
    .CNT_WIDTH(2)
  ) dut (
    .CLOCK        (CLOCK),
    .RESET        (RESET),
    .IMEM_ADDR    (IMEM_ADDR),
    .IMEM_DATA    (IMEM_DATA),
    .ID_EX_MemRead(ID_EX_MemRead),
    .ID_EX_RT     (ID_EX_RT),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .PC           (PC),
    .Instruction  (Instruction),
    .PCPlus4      (PCPlus4),
    .Valid        (Valid),
    .Stall        (Stall),
    .StallCount   (StallCount),
    .FlushCount   (FlushCount)
  );

  // 10 ns clock; rising edges at 5, 15, 25, ...
  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  // Counts one comparison and reports it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drives all DUT inputs for the coming edge.
  task automatic applyStimulus(input logic memRead, input logic [4:0] rt, input logic taken,
                               input logic [31:0] target, input logic [31:0] data);
    ID_EX_MemRead = memRead;
    ID_EX_RT      = rt;
    BranchTaken   = taken;
    BranchTarget  = target;
    IMEM_DATA     = data;
    #1;
  endtask

  // Advances one rising edge and settles 1 ns past it.
  task automatic stepClock();
    @(posedge CLOCK);
    #1;
  endtask

  // Checks the IF/ID-visible state in one call.
  task automatic checkState(input string tag, input logic [31:0] expPc, input logic [31:0] expInstr,
                            input logic [31:0] expPcPlus4, input logic expValid);
    checkOutput({tag, ".pc"}, PC, expPc);
    checkOutput({tag, ".instr"}, Instruction, expInstr);
    checkOutput({tag, ".pcplus4"}, PCPlus4, expPcPlus4);
    checkOutput({tag, ".valid"}, {31'd0, Valid}, {31'd0, expValid});
  endtask

  // Saturating 2-bit stall counter expectation carried across the hold loop.
  logic [1:0] expStall;

  initial begin
    vecCount  = 0;
    failCount = 0;
    RESET     = 1'b0;
    applyStimulus(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);

    // Reset state, checked before any clock edge
    checkState("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    checkOutput("reset.stall", {31'd0, Stall}, 32'd0);
    checkOutput("reset.stallcnt", {30'd0, StallCount}, 32'd0);
    checkOutput("reset.flushcnt", {30'd0, FlushCount}, 32'd0);
    RESET = 1'b1;

    // First fetch
    applyStimulus(1'b0, 5'd0, 1'b0, 32'd0, 32'h8C08_0004);
    checkOutput("first.imemaddr", IMEM_ADDR, 32'h0);
    checkOutput("first.stall", {31'd0, Stall}, 32'd0);
    stepClock();
    checkState("first", 32'h4, 32'h8C08_0004, 32'h4, 1'b1);

    // Sequential run to PC=16
    applyStimulus(1'b0, 5'd0, 1'b0, 32'd0, 32'h2000_0008);
    stepClock();
    checkState("seq8", 32'h8, 32'h2000_0008, 32'h8, 1'b1);
    applyStimulus(1'b0, 5'd0, 1'b0, 32'd0, 32'h2000_000C);
    stepClock();
    checkState("seq12", 32'hC, 32'h2000_000C, 32'hC, 1'b1);
    applyStimulus(1'b0, 5'd0, 1'b0, 32'd0, 32'h0109_5020);
    stepClock();
    checkState("seq16", 32'h10, 32'h0109_5020, 32'h10, 1'b1);
    checkOutput("seq16.imemaddr", IMEM_ADDR, 32'h10);

    // Load-use on rs=8: one stalled edge
    applyStimulus(1'b1, 5'd8, 1'b0, 32'd0, 32'h012A_5820);
    checkOutput("lu.rs.stall", {31'd0, Stall}, 32'd1);
    stepClock();
    checkState("lu.hold", 32'h10, 32'h0109_5020, 32'h10, 1'b1);
    checkOutput("lu.stallcnt", {30'd0, StallCount}, 32'd1);

    // Match on rt=9 also stalls; RT=0 never does
    applyStimulus(1'b1, 5'd9, 1'b0, 32'd0, 32'h012A_5820);
    checkOutput("lu.rt.stall", {31'd0, Stall}, 32'd1);
    applyStimulus(1'b1, 5'd0, 1'b0, 32'd0, 32'h012A_5820);
    checkOutput("lu.rt0.stall", {31'd0, Stall}, 32'd0);
    stepClock();
    checkState("lu.adv", 32'h14, 32'h012A_5820, 32'h14, 1'b1);
    checkOutput("lu.adv.stallcnt", {30'd0, StallCount}, 32'd1);

    // Flush wins over simultaneous stall (IF/ID rt=10)
    applyStimulus(1'b1, 5'd10, 1'b1, 32'h0000_0043, 32'h3000_0014);
    checkOutput("flush.stall", {31'd0, Stall}, 32'd1);
    stepClock();
    checkState("flush", 32'h40, 32'h0, 32'h0, 1'b0);
    checkOutput("flush.flushcnt", {30'd0, FlushCount}, 32'd1);
    checkOutput("flush.stallcnt", {30'd0, StallCount}, 32'd1);

    // Bubble does not stall; next edge fetches from the target
    applyStimulus(1'b1, 5'd10, 1'b0, 32'd0, 32'h2400_0040);
    checkOutput("bubble.stall", {31'd0, Stall}, 32'd0);
    stepClock();
    checkState("target", 32'h44, 32'h2400_0040, 32'h44, 1'b1);

    // Redirect to top of memory (low bits masked), then wrap
    applyStimulus(1'b0, 5'd0, 1'b1, 32'hFFFF_FFFF, 32'h0);
    stepClock();
    checkState("wrap.redir", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
    checkOutput("wrap.flushcnt", {30'd0, FlushCount}, 32'd2);
    applyStimulus(1'b0, 5'd0, 1'b0, 32'd0, 32'h2800_FFFC);
    stepClock();
    checkState("wrap.adv1", 32'h0, 32'h2800_FFFC, 32'h0, 1'b1);
    applyStimulus(1'b0, 5'd0, 1'b0, 32'd0, 32'h0109_5020);
    stepClock();
    checkState("wrap.adv2", 32'h4, 32'h0109_5020, 32'h4, 1'b1);

    // Hold hazard (rt=9) for 5 edges; 2-bit counter saturates at 3
    expStall = 2'd1;
    applyStimulus(1'b1, 5'd9, 1'b0, 32'd0, 32'h3C00_0004);
    for (int i = 0; i < 5; i++) begin
      stepClock();
      if (expStall != 2'd3) expStall = expStall + 2'd1;
      checkOutput($sformatf("sat%0d.stallcnt", i), {30'd0, StallCount}, {30'd0, expStall});
      checkOutput($sformatf("sat%0d.pc", i), PC, 32'h4);
    end
    checkOutput("sat.final", {30'd0, StallCount}, 32'd3);

    // Asynchronous reset mid-stall, between edges
    #2;
    RESET = 1'b0;
    #1;
    checkState("areset", 32'h0, 32'h0, 32'h0, 1'b0);
    checkOutput("areset.stall", {31'd0, Stall}, 32'd0);
    checkOutput("areset.stallcnt", {30'd0, StallCount}, 32'd0);
    checkOutput("areset.flushcnt", {30'd0, FlushCount}, 32'd0);
    RESET = 1'b1;

    // Flush counter saturation over four consecutive flushes
    applyStimulus(1'b0, 5'd0, 1'b1, 32'h0000_0100, 32'h0);
    for (int i = 0; i < 4; i++) begin
      stepClock();
      checkOutput($sformatf("fsat%0d.flushcnt", i), {30'd0, FlushCount},
                  (i < 3) ? 32'(i + 1) : 32'd3);
    end
    checkState("fsat", 32'h100, 32'h0, 32'h0, 1'b0);
    checkOutput("fsat.stallcnt", {30'd0, StallCount}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register sitting directly upstream of the register file. It holds the PC and drives the instruction-memory address. It latches the fetched word into the Instruction bus that feeds register-file operand decode (fields [25:21]/[20:16]). It also detects load-use hazards, stalls fetch, and flushes on taken branches resolved in EX.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_WORD, 32'h0000_0000, word inserted into IF/ID on flush/reset (sll $0,$0,0)
CNT_WIDTH, 16, width of saturating stall/flush performance counters

Ports:
CLOCK  input  1  single clock; all state updates on rising edge
RESET  input  1  asynchronous, active-low reset
IMEM_ADDR  output  32  instruction-memory address; combinationally equal to PC
IMEM_DATA  input  32  instruction word at IMEM_ADDR; combinational memory, same cycle
ID_EX_MemRead  input  1  instruction now in ID/EX is a load
ID_EX_RT  input  5  destination (rt) of that load
BranchTaken  input  1  EX-stage branch/jump resolved taken this cycle
BranchTarget  input  32  redirect address, valid with BranchTaken
PC  output  32  current fetch PC (registered)
Instruction  output  32  IF/ID instruction register, drives register-file decode
PCPlus4  output  32  IF/ID copy of fetch PC + 4
Valid  output  1  IF/ID holds a real instruction (0 = bubble)
Stall  output  1  load-use hazard this cycle; downstream zeroes ID/EX control
StallCount  output  CNT_WIDTH  saturating count of stall cycles
FlushCount  output  CNT_WIDTH  saturating count of taken-branch flushes

Behaviour:
- Reset (RESET=0, asynchronous, immediate, also mid-operation): PC=RESET_PC, Instruction=NOP_WORD, PCPlus4=0, Valid=0, StallCount=0, FlushCount=0. Stall then evaluates to 0 because Valid=0.
- IMEM_ADDR = PC at all times, with no register between them.
- Hazard detect, combinational on current state: Stall = Valid & ID_EX_MemRead & (ID_EX_RT != 0) & (ID_EX_RT == Instruction[25:21] | ID_EX_RT == Instruction[20:16]).
  - Compares both fields regardless of opcode. Conservative extra stalls are acceptable.
- Per rising edge, priority order is Flush > Stall > Advance:
  - Flush (BranchTaken=1):
    - PC <= {BranchTarget[31:2],2'b00}
    - Instruction <= NOP_WORD, Valid <= 0, PCPlus4 <= 0
    - FlushCount++ (saturating)
    - Wins over a simultaneous Stall, because the branch is the older instruction. StallCount is not incremented.
  - Stall (BranchTaken=0, Stall=1): PC, Instruction, PCPlus4 and Valid all hold. StallCount++ (saturating).
  - Advance (otherwise): PC <= PC+4; Instruction <= IMEM_DATA; PCPlus4 <= PC+4; Valid <= 1.
- Latency: the word at PC=N appears on Instruction one edge after the edge that made PC=N. A redirect costs exactly one bubble in IF/ID.
- Arithmetic: PC+4 is modulo 2^32, so 32'hFFFF_FFFC advances to 32'h0000_0000 with PCPlus4=0. PC[1:0] is always 00.
- Counters stick at all-ones and never wrap. They are cleared only by reset.
- A bubble (Valid=0) never raises Stall, even if its fields match ID_EX_RT.
- Stall persists while the inputs persist. The block places no limit on stall length; the pipeline normally drops ID_EX_MemRead after one cycle.

Test Plan:
- Reset/first fetch: RESET low then high, IMEM_DATA=32'h8C08_0004 -> before edge PC=0, Valid=0, Stall=0; after 1st edge Instruction=32'h8C08_0004, PCPlus4=4, PC=4, Valid=1.
- Sequential run: 4 edges with no hazard -> PC goes 4,8,12,16. Instruction tracks the memory word at the previous PC each cycle.
- Load-use: Instruction=32'h0109_5020 (rs=8, rt=9), ID_EX_MemRead=1, ID_EX_RT=8 for one cycle -> Stall=1, PC and Instruction held one edge, StallCount=1. Repeat with ID_EX_RT=0 -> Stall=0.
- Branch flush with simultaneous stall: BranchTaken=1, BranchTarget=32'h0000_0043, Stall condition true -> next edge PC=32'h40, Valid=0, Instruction=0, FlushCount=1, StallCount unchanged. The following edge fetches from 32'h40.
- PC wrap: redirect to 32'hFFFF_FFFC, then advance twice -> PC=32'h0, then PCPlus4 = 0 for the word fetched at FFFF_FFFC.
- Async reset mid-stall plus counter saturation: assert RESET low between edges during a stall -> all outputs reset immediately without waiting for a clock edge. With CNT_WIDTH=2, hold the hazard 5 edges -> StallCount=3 and stays 3.
